vga_timing_ctrl: RTL and testbench

Run/stop controller and sync generator for the VGA pixel pipeline on the 25 MHz pixel clock. It sequences a horizontal pixel counter and a vertical line counter through the active, front-porch, sync and back-porch phases. It produces hsync, vsync, video_on, pixel coordinates and line/frame strobes for the pixel-generation logic. Stop requests are deferred to a frame boundary, so the monitor never sees a truncated frame.

---
 rtl/vga_timing_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// ---------------
// Run/stop controller and sync generator for the VGA pixel pipeline, clocked
// by the 25 MHz pixel clock. A horizontal pixel counter and a vertical line
// counter step through the active, front-porch, sync and back-porch phases.
// Stop requests take effect only at the end of a frame, so the monitor never
// sees a truncated frame.
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//   When defined, adds frame_count_o, a 16-bit wrapping count of completed
//   frames. It is cleared only by reset_n and holds its value while idle.
//
// Ports
//   clk_25m        in   pixel clock, rising edge
//   reset_n        in   asynchronous, active-low reset
//   start_i        in   single-cycle start request
//   stop_req_i     in   single-cycle request to stop at the end of the frame
//   busy_o         out  high while running or stopping
//   hsync_o        out  horizontal sync (active level HSYNC_POL)
//   vsync_o        out  vertical sync (active level VSYNC_POL)
//   video_on_o     out  current pixel is inside the visible area
//   pixel_x_o      out  current horizontal count (raw, qualify with video_on_o)
//   pixel_y_o      out  current vertical count (raw, qualify with video_on_o)
//   line_start_o   out  one-cycle pulse at h=0 of every line while busy
//   frame_start_o  out  one-cycle pulse at h=0, v=0 while busy
//   frame_count_o  out  completed-frame count (VGA_TIMING_FRAME_CNT_EN only)
//   dbg_state_o    out  control FSM state: 0=IDLE, 1=RUN, 2=STOPPING
//
// Handshake: start_i and stop_req_i are single-cycle pulses sampled on the
// rising edge; there is no ready. stop_req_i wins over start_i in the same
// cycle. Every output is registered and describes the pixel at the current
// counter values, with no combinational path from the inputs.

module vga_timing_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int H_BITS    = 10,
    parameter int V_BITS    = 10
) (
    input  logic              clk_25m,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              stop_req_i,
    output logic              busy_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              video_on_o,
    output logic [H_BITS-1:0] pixel_x_o,
    output logic [V_BITS-1:0] pixel_y_o,
    output logic              line_start_o,
    output logic              frame_start_o,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]       frame_count_o,
`endif
    output logic [1:0]        dbg_state_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Count values at which each phase begins.
    localparam logic [H_BITS-1:0] H_LAST  = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0] H_FP_AT = H_BITS'(H_ACTIVE);
    localparam logic [H_BITS-1:0] H_SY_AT = H_BITS'(H_ACTIVE + H_FP);
    localparam logic [H_BITS-1:0] H_BP_AT = H_BITS'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_BITS-1:0] V_LAST  = V_BITS'(V_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_FP_AT = V_BITS'(V_ACTIVE);
    localparam logic [V_BITS-1:0] V_SY_AT = V_BITS'(V_ACTIVE + V_FP);
    localparam logic [V_BITS-1:0] V_BP_AT = V_BITS'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic H_ON = (HSYNC_POL != 0);
    localparam logic V_ON = (VSYNC_POL != 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } ctrl_t;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

    // Shared phase sequencer for both axes; the flags say whether the next
    // count is the first count of the following phase.
    function automatic phase_t step_phase(input phase_t ph, input logic to_fp,
                                          input logic to_sync, input logic to_bp,
                                          input logic to_act);
        phase_t nxt;
        nxt = ph;
        case (ph)
            PH_ACT:  if (to_fp)   nxt = PH_FP;
            PH_FP:   if (to_sync) nxt = PH_SYNC;
            PH_SYNC: if (to_bp)   nxt = PH_BP;
            PH_BP:   if (to_act)  nxt = PH_ACT;
            default: nxt = PH_ACT;
        endcase
        return nxt;
    endfunction

    ctrl_t             ctrl_q, ctrl_d;
    phase_t            h_ph_q, h_ph_d, v_ph_q, v_ph_d;
    logic [H_BITS-1:0] h_cnt_q, h_cnt_d;
    logic [V_BITS-1:0] v_cnt_q, v_cnt_d;
    logic              busy_q, hsync_q, vsync_q, video_on_q;
    logic              line_start_q, frame_start_q;
    logic [H_BITS-1:0] pixel_x_q;
    logic [V_BITS-1:0] pixel_y_q;
    logic              h_wrap, frame_end, advance, busy_d;

    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        frame_end = h_wrap && (v_cnt_q == V_LAST);

        ctrl_d = ctrl_q;
        case (ctrl_q)
            ST_IDLE:     if (start_i && !stop_req_i) ctrl_d = ST_RUN;
            ST_RUN:      if (stop_req_i) ctrl_d = ST_STOPPING;
            ST_STOPPING: begin
                if (start_i && !stop_req_i) ctrl_d = ST_RUN;
                else if (frame_end)         ctrl_d = ST_IDLE;
            end
            default:     ctrl_d = ST_IDLE;
        endcase
        busy_d = (ctrl_d != ST_IDLE);

        // Counters move only while busy before and after the edge: the start
        // edge leaves them at 0 so the first busy cycle shows pixel (0,0),
        // and the stop edge clears them.
        advance = (ctrl_q != ST_IDLE) && (ctrl_d != ST_IDLE);

        h_cnt_d = '0;
        v_cnt_d = '0;
        h_ph_d  = PH_ACT;
        v_ph_d  = PH_ACT;
        if (advance) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            v_cnt_d = v_cnt_q;
            if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            h_ph_d = step_phase(h_ph_q, h_cnt_d == H_FP_AT, h_cnt_d == H_SY_AT,
                                h_cnt_d == H_BP_AT, h_cnt_d == '0);
            v_ph_d = h_wrap ? step_phase(v_ph_q, v_cnt_d == V_FP_AT, v_cnt_d == V_SY_AT,
                                         v_cnt_d == V_BP_AT, v_cnt_d == '0)
                            : v_ph_q;
        end
    end

    // Outputs are computed from the next-state values so they line up with
    // the counters on the same edge.
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= ST_IDLE;
            h_ph_q        <= PH_ACT;
            v_ph_q        <= PH_ACT;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            busy_q        <= 1'b0;
            hsync_q       <= ~H_ON;
            vsync_q       <= ~V_ON;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            h_ph_q        <= h_ph_d;
            v_ph_q        <= v_ph_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            busy_q        <= busy_d;
            hsync_q       <= (busy_d && h_ph_d == PH_SYNC) ? H_ON : ~H_ON;
            vsync_q       <= (busy_d && v_ph_d == PH_SYNC) ? V_ON : ~V_ON;
            video_on_q    <= busy_d && (h_ph_d == PH_ACT) && (v_ph_d == PH_ACT);
            line_start_q  <= busy_d && (h_cnt_d == '0);
            frame_start_q <= busy_d && (h_cnt_d == '0) && (v_cnt_d == '0);
            pixel_x_q     <= h_cnt_d;
            pixel_y_q     <= v_cnt_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_count_q;

    // Counts every completed frame while busy, including the last frame of a
    // stop; wraps naturally at 16 bits.
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n)                          frame_count_q <= '0;
        else if (ctrl_q != ST_IDLE && frame_end) frame_count_q <= frame_count_q + 16'd1;
    end

    assign frame_count_o = frame_count_q;
`endif

    assign busy_o        = busy_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign video_on_o    = video_on_q;
    assign pixel_x_o     = pixel_x_q;
    assign pixel_y_o     = pixel_y_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign dbg_state_o   = ctrl_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl. The DUT runs with a reduced
// raster (30 x 15) so several complete frames fit in a short run. The
// reference model keeps one linear position inside the frame plus a
// running / stop-pending flag, and derives every output from that position
// with plain division and range tests.
module tb_vga_timing_ctrl;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int HB_W = 10, VB_W = 10;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int OW = 6 + HB_W + VB_W + 16;
`else
  localparam int OW = 6 + HB_W + VB_W;
`endif

  // ---------------- clock / reset ----------------
  logic clk_25m = 1'b0;
  logic reset_n = 1'b0;
  logic start_i = 1'b0;
  logic stop_req_i = 1'b0;
  logic busy_o, hsync_o, vsync_o, video_on_o, line_start_o, frame_start_o;
  logic [HB_W-1:0] pixel_x_o;
  logic [VB_W-1:0] pixel_y_o;
  logic [1:0] dbg_state_o;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_o;
`endif

  initial forever #5 clk_25m = ~clk_25m;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .H_BITS(HB_W), .V_BITS(VB_W)
  ) dut (
    .clk_25m(clk_25m),
    .reset_n(reset_n),
    .start_i(start_i),
    .stop_req_i(stop_req_i),
    .busy_o(busy_o),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .video_on_o(video_on_o),
    .pixel_x_o(pixel_x_o),
    .pixel_y_o(pixel_y_o),
    .line_start_o(line_start_o),
    .frame_start_o(frame_start_o),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_count_o(frame_count_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- reference model ----------------
  bit m_running = 0;
  bit m_pending = 0;
  int m_pos = 0;
  int m_fc = 0;

  function automatic logic [OW-1:0] expect_vec();
    int h, v;
    logic hs, vs, vid, ls, fs;
    logic [OW-1:0] vec;
    h = m_pos % HT;
    v = m_pos / HT;
    hs = !(m_running && h >= HA + HF && h < HA + HF + HS);
    vs = !(m_running && v >= VA + VF && v < VA + VF + VS);
    vid = m_running && h < HA && v < VA;
    ls = m_running && h == 0;
    fs = m_running && m_pos == 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    vec = {m_running, hs, vs, vid, ls, fs, HB_W'(h), VB_W'(v), 16'(m_fc)};
`else
    vec = {m_running, hs, vs, vid, ls, fs, HB_W'(h), VB_W'(v)};
`endif
    return vec;
  endfunction

  function automatic logic [OW-1:0] reset_vec();
    logic [OW-1:0] vec;
    vec = '0;
    vec[OW-2] = 1'b1;  // hsync idle high
    vec[OW-3] = 1'b1;  // vsync idle high
    return vec;
  endfunction

  function automatic logic [OW-1:0] act_vec();
`ifdef VGA_TIMING_FRAME_CNT_EN
    return {busy_o, hsync_o, vsync_o, video_on_o, line_start_o, frame_start_o,
            pixel_x_o, pixel_y_o, frame_count_o};
`else
    return {busy_o, hsync_o, vsync_o, video_on_o, line_start_o, frame_start_o,
            pixel_x_o, pixel_y_o};
`endif
  endfunction

  // Advance the model across one clock edge with the given request inputs.
  task automatic model_step(input bit st, input bit sp);
    bit fe, was_pending;
    if (!m_running) begin
      if (st && !sp) begin
        m_running = 1;
        m_pending = 0;
        m_pos = 0;
      end
    end else begin
      fe = (m_pos == FR - 1);
      was_pending = m_pending;
      if (sp) m_pending = 1;
      else if (st) m_pending = 0;
      if (fe) m_fc = (m_fc + 1) % 65536;
      if (fe && was_pending && m_pending) begin
        m_running = 0;
        m_pending = 0;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FR;
      end
    end
  endtask

  task automatic model_reset();
    m_running = 0;
    m_pending = 0;
    m_pos = 0;
    m_fc = 0;
  endtask

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h expected=%h (busy,hs,vs,vid,ls,fs,x,y[,fc])",
               name, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled 2 ns after the edge.
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(posedge clk_25m);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", act_vec(), e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit st, input bit sp);
    @(negedge clk_25m);
    start_i = st;
    stop_req_i = sp;
    model_step(st, sp);
    exp_q.push_back(expect_vec());
  endtask

  task automatic run_to_pos(input int target, input int budget);
    int n;
    n = 0;
    while (m_pos != target && n < budget) begin
      drive(0, 0);
      n++;
    end
    if (m_pos != target) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_to_pos got=%0d expected=%0d", m_pos, target);
    end
  endtask

  task automatic run_to_idle(input int budget);
    int n;
    n = 0;
    while (m_running && n < budget) begin
      drive(0, 0);
      n++;
    end
  endtask

  // Assert reset between edges, check outputs before any edge, then release.
  task automatic async_reset(input string name);
    @(negedge clk_25m);
    start_i = 0;
    stop_req_i = 0;
    #1 reset_n = 0;
    #1 check(name, act_vec(), reset_vec());
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk_25m);
    reset_n = 1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog got=timeout expected=finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    repeat (2) @(negedge clk_25m);
    #1 check("reset_values", act_vec(), reset_vec());
    @(negedge clk_25m);
    reset_n = 1;

    // Idle: stop alone and start+stop together are both ignored.
    repeat (3) drive(0, 0);
    drive(0, 1);
    drive(1, 1);
    repeat (3) drive(0, 0);

    // Start, then two free-running frames with stray start pulses.
    drive(1, 0);
    for (int i = 0; i < 2 * FR + 5; i++) drive(($urandom_range(0, 40) == 0), 0);

    // Stop mid-frame: finish the frame, then idle.
    run_to_pos(5 * HT + 3, FR);
    drive(0, 1);
    run_to_idle(2 * FR);
    repeat (10) drive(0, 0);

    // Start+stop together in RUN goes to stopping; a later start cancels it.
    drive(1, 0);
    repeat (20) drive(0, 0);
    drive(1, 1);
    run_to_pos(FR - 20, FR);
    drive(1, 0);
    run_to_pos(FR - 1, FR);
    repeat (HT + 5) drive(0, 0);

    // Stop, then cancel on the very last edge of the frame.
    drive(0, 1);
    run_to_pos(FR - 1, FR);
    drive(1, 0);
    repeat (HT) drive(0, 0);

    // Stop and let it end, with start+stop on the last edge (stays stopping).
    drive(0, 1);
    run_to_pos(FR - 1, FR);
    drive(1, 1);
    repeat (5) drive(0, 0);

    // Randomized request traffic.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 299);
      drive(r < 4 || r == 9, (r >= 4 && r < 7) || r == 9);
    end

    // Reset in the middle of a line.
    if (!m_running) drive(1, 0);
    run_to_pos(7 * HT + 11, 2 * FR);
    async_reset("reset_mid_frame");
    repeat (15) drive(0, 0);
    drive(1, 0);
    repeat (FR + 50) drive($urandom_range(0, 60) == 0, 0);

    repeat (3) @(negedge clk_25m);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
